// File: rtl/cpu_pkg.sv
// cpu_pkg: shared opcodes, ALU codes, instruction field positions and sequencer states
package cpu_pkg;
   localparam logic [4:0] OP_NOP  = 5'h00;
   localparam logic [4:0] OP_ADD  = 5'h01;
   localparam logic [4:0] OP_ADDI = 5'h02;
   localparam logic [4:0] OP_SUB  = 5'h03;
   localparam logic [4:0] OP_SUBI = 5'h04;
   localparam logic [4:0] OP_AND  = 5'h05;
   localparam logic [4:0] OP_OR   = 5'h06;
   localparam logic [4:0] OP_JMP  = 5'h07;
   localparam logic [4:0] OP_BZ   = 5'h08;
   localparam logic [4:0] OP_HALT = 5'h1f;
   localparam logic [2:0] ALU_ADD = 3'd0;
   localparam logic [2:0] ALU_SUB = 3'd1;
   localparam logic [2:0] ALU_AND = 3'd2;
   localparam logic [2:0] ALU_OR  = 3'd3;
   localparam int OPC_HI = 15;
   localparam int OPC_LO = 11;
   localparam int RD_HI  = 10;
   localparam int RD_LO  = 8;
   localparam int RS_HI  = 7;
   localparam int RS_LO  = 5;
   localparam int IMM_HI = 7;
   localparam int IMM_LO = 0;
   typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_ISSUE, S_WAIT, S_HALT} state_t;
endpackage

// File: rtl/cpu_instr_decode.sv
// cpu_instr_decode: combinational classification of a 16-bit instruction word
module cpu_instr_decode
   import cpu_pkg::*;
(
   input  logic [15:0] instr,
   output logic        is_alu,
   output logic        is_imm,
   output logic        is_jmp,
   output logic        is_bz,
   output logic        is_halt,
   output logic        is_illegal,
   output logic [2:0]  alu_op
);
   logic [4:0] opc;
   always_comb begin
      opc        = instr[OPC_HI:OPC_LO];
      is_alu     = opc >= OP_ADD && opc <= OP_OR;
      is_imm     = opc == OP_ADDI || opc == OP_SUBI;
      is_jmp     = opc == OP_JMP;
      is_bz      = opc == OP_BZ;
      is_halt    = opc == OP_HALT;
      is_illegal = !(opc == OP_NOP || is_alu || is_jmp || is_bz || is_halt);
      alu_op     = (opc == OP_SUB || opc == OP_SUBI) ? ALU_SUB :
                   opc == OP_AND ? ALU_AND : opc == OP_OR ? ALU_OR : ALU_ADD;
   end
endmodule

// File: rtl/cpu_seq_ctrl.sv
// cpu_seq_ctrl: multi-cycle fetch/decode/issue/wait/writeback sequencer owning pc and zero flag
module cpu_seq_ctrl
   import cpu_pkg::*;
#(
   parameter int DWIDTH   = 16,
   parameter int PC_WIDTH = 8,
   parameter int TIMEOUT  = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic [DWIDTH-1:0]   instr_q,
   input  logic                alu_valid,
   input  logic                alu_zero,
   output logic [PC_WIDTH-1:0] pc,
   output logic                rom_en,
   output logic                rf_rd_en,
   output logic [2:0]          rd_addr,
   output logic [2:0]          rs_addr,
   output logic                alu_mux_en,
   output logic                alu_in_sel,
   output logic [7:0]          offset,
   output logic [2:0]          alu_op,
   output logic                wb_en,
   output logic                busy,
   output logic                halted,
   output logic                fault
);
   state_t              state_q, state_d;
   logic [PC_WIDTH-1:0] pc_q, pc_d;
   logic                zero_q, zero_d, fault_q, fault_d;
   logic [7:0]          cnt_q, cnt_d;
   logic                rom_en_q, rom_en_d, rf_rd_en_q, rf_rd_en_d;
   logic                mux_en_q, mux_en_d, wb_en_q, wb_en_d;
   logic [2:0]          rd_q, rd_d, rs_q, rs_d, op_q, op_d;
   logic [7:0]          off_q, off_d;
   logic                sel_q, sel_d;
   logic                is_alu, is_imm, is_jmp, is_bz, is_halt, is_illegal;
   logic [2:0]          dec_op;
   cpu_instr_decode u_dec (
      .instr      (instr_q[15:0]),
      .is_alu     (is_alu),
      .is_imm     (is_imm),
      .is_jmp     (is_jmp),
      .is_bz      (is_bz),
      .is_halt    (is_halt),
      .is_illegal (is_illegal),
      .alu_op     (dec_op)
   );
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      zero_d     = zero_q;
      fault_d    = fault_q;
      cnt_d      = cnt_q;
      rd_d       = rd_q;
      rs_d       = rs_q;
      off_d      = off_q;
      op_d       = op_q;
      sel_d      = sel_q;
      rf_rd_en_d = 1'b0;
      mux_en_d   = 1'b0;
      wb_en_d    = 1'b0;
      case (state_q)
         S_IDLE:   if (start) state_d = S_FETCH;
         S_FETCH:  state_d = S_DECODE;
         S_DECODE: begin
            if (is_alu) begin
               rd_d       = instr_q[RD_HI:RD_LO];
               rs_d       = instr_q[RS_HI:RS_LO];
               off_d      = instr_q[IMM_HI:IMM_LO];
               op_d       = dec_op;
               sel_d      = !is_imm;
               rf_rd_en_d = 1'b1;
               state_d    = S_ISSUE;
            end else if (is_halt) begin
               state_d = S_HALT;
            end else begin
               pc_d    = (is_jmp || (is_bz && zero_q)) ? PC_WIDTH'(instr_q[IMM_HI:IMM_LO])
                                                       : pc_q + PC_WIDTH'(1);
               fault_d = fault_q | is_illegal;
               state_d = S_FETCH;
            end
         end
         S_ISSUE: begin
            mux_en_d = 1'b1;
            cnt_d    = '0;
            state_d  = S_WAIT;
         end
         S_WAIT: begin
            if (alu_valid) begin
               wb_en_d = 1'b1;
               zero_d  = alu_zero;
               pc_d    = pc_q + PC_WIDTH'(1);
               state_d = S_FETCH;
            end else if (cnt_q == 8'(TIMEOUT - 1)) begin
               fault_d = 1'b1;
               state_d = S_HALT;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         default: ;
      endcase
      rom_en_d = state_d == S_FETCH;
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         pc_q       <= '0;
         zero_q     <= 1'b0;
         fault_q    <= 1'b0;
         cnt_q      <= '0;
         rom_en_q   <= 1'b0;
         rf_rd_en_q <= 1'b0;
         mux_en_q   <= 1'b0;
         wb_en_q    <= 1'b0;
         rd_q       <= '0;
         rs_q       <= '0;
         off_q      <= '0;
         op_q       <= '0;
         sel_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         zero_q     <= zero_d;
         fault_q    <= fault_d;
         cnt_q      <= cnt_d;
         rom_en_q   <= rom_en_d;
         rf_rd_en_q <= rf_rd_en_d;
         mux_en_q   <= mux_en_d;
         wb_en_q    <= wb_en_d;
         rd_q       <= rd_d;
         rs_q       <= rs_d;
         off_q      <= off_d;
         op_q       <= op_d;
         sel_q      <= sel_d;
      end
   end
   assign pc         = pc_q;
   assign rom_en     = rom_en_q;
   assign rf_rd_en   = rf_rd_en_q;
   assign rd_addr    = rd_q;
   assign rs_addr    = rs_q;
   assign alu_mux_en = mux_en_q;
   assign alu_in_sel = sel_q;
   assign offset     = off_q;
   assign alu_op     = op_q;
   assign wb_en      = wb_en_q;
   assign busy       = state_q != S_IDLE && state_q != S_HALT;
   assign halted     = state_q == S_HALT;
   assign fault      = fault_q;
endmodule

// File: tb/tb_cpu_seq_ctrl.sv
// tb_cpu_seq_ctrl: instruction-level model of the sequencer checked against the DUT every cycle
module tb_cpu_seq_ctrl;
   localparam int T = 8;
   logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, alu_valid = 1'b0, alu_zero = 1'b0;
   logic [15:0] instr_q = '0;
   logic [7:0]  pc, offset;
   logic [2:0]  rd_addr, rs_addr, alu_op;
   logic        rom_en, rf_rd_en, alu_mux_en, alu_in_sel, wb_en, busy, halted, fault;
   always #5 clk = ~clk;
   cpu_seq_ctrl #(.DWIDTH(16), .PC_WIDTH(8), .TIMEOUT(T)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .instr_q(instr_q), .alu_valid(alu_valid),
      .alu_zero(alu_zero), .pc(pc), .rom_en(rom_en), .rf_rd_en(rf_rd_en), .rd_addr(rd_addr),
      .rs_addr(rs_addr), .alu_mux_en(alu_mux_en), .alu_in_sel(alu_in_sel), .offset(offset),
      .alu_op(alu_op), .wb_en(wb_en), .busy(busy), .halted(halted), .fault(fault)
   );
   logic [15:0] rom [256];
   int          alu_lat = 1;
   bit          stray = 1'b0, zval = 1'b0;
   int          checks = 0, failures = 0;
   bit          chk_en = 1'b0;
   int          cyc_n = 0, last_fetch = 0, prev_fetch = 0, wb_cnt = 0, wb_base = 0;
   bit          r_pend = 1'b0;
   logic [7:0]  r_addr = '0;
   int          r_cnt = 0;
   logic [7:0]  m_pc, m_off, e_pc, e_off;
   logic [2:0]  m_rd, m_rs, m_op, e_rd, e_rs, e_op;
   bit          m_zero, m_fault, m_halt, m_idle, m_wb, m_sel;
   bit          e_rom, e_rf, e_mux, e_wb, e_busy, e_halt, e_fault, e_sel;
   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc_n);
      end
   endtask
   // synchronous ROM and an ALU that answers alu_lat cycles after the mux enable
   initial forever begin
      @(posedge clk);
      #1;
      if (r_pend) instr_q = rom[r_addr];
      r_pend    = rom_en;
      r_addr    = pc;
      alu_zero  = zval;
      alu_valid = stray;
      if (r_cnt > 0) begin
         r_cnt--;
         if (r_cnt == 0) alu_valid = 1'b1;
      end
      if (alu_mux_en && alu_lat > 0) r_cnt = alu_lat;
   end
   initial forever begin
      @(negedge clk);
      cyc_n++;
      if (chk_en) begin
         chk("pc", 16'(pc), 16'(e_pc));
         chk("rom_en", 16'(rom_en), 16'(e_rom));
         chk("rf_rd_en", 16'(rf_rd_en), 16'(e_rf));
         chk("alu_mux_en", 16'(alu_mux_en), 16'(e_mux));
         chk("wb_en", 16'(wb_en), 16'(e_wb));
         chk("busy", 16'(busy), 16'(e_busy));
         chk("halted", 16'(halted), 16'(e_halt));
         chk("fault", 16'(fault), 16'(e_fault));
         chk("rd_addr", 16'(rd_addr), 16'(e_rd));
         chk("rs_addr", 16'(rs_addr), 16'(e_rs));
         chk("offset", 16'(offset), 16'(e_off));
         chk("alu_op", 16'(alu_op), 16'(e_op));
         chk("alu_in_sel", 16'(alu_in_sel), 16'(e_sel));
      end
      if (rom_en === 1'b1) begin
         prev_fetch = last_fetch;
         last_fetch = cyc_n;
      end
      if (wb_en === 1'b1) wb_cnt++;
   end
   task automatic cyc(input bit rom_x, input bit rf_x, input bit mux_x);
      e_pc    = m_pc;
      e_rom   = rom_x;
      e_rf    = rf_x;
      e_mux   = mux_x;
      e_wb    = m_wb;
      m_wb    = 1'b0;
      e_busy  = !m_idle && !m_halt;
      e_halt  = m_halt;
      e_fault = m_fault;
      e_rd    = m_rd;
      e_rs    = m_rs;
      e_off   = m_off;
      e_op    = m_op;
      e_sel   = m_sel;
      @(posedge clk);
      #1;
   endtask
   task automatic m_reset();
      m_pc = '0; m_zero = 1'b0; m_fault = 1'b0; m_halt = 1'b0; m_idle = 1'b1; m_wb = 1'b0;
      m_rd = '0; m_rs = '0; m_off = '0; m_op = '0; m_sel = 1'b0;
   endtask
   task automatic m_ops(input logic [15:0] ins);
      logic [4:0] opc;
      opc   = ins[15:11];
      m_rd  = ins[10:8];
      m_rs  = ins[7:5];
      m_off = ins[7:0];
      m_sel = opc inside {5'd1, 5'd3, 5'd5, 5'd6};
      m_op  = opc inside {5'd1, 5'd2} ? 3'd0 : opc inside {5'd3, 5'd4} ? 3'd1 : opc == 5'd5 ? 3'd2 : 3'd3;
   endtask
   task automatic m_instr();
      logic [15:0] ins;
      logic [4:0]  opc;
      ins = rom[m_pc];
      opc = ins[15:11];
      cyc(1'b1, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0);
      if (opc inside {[5'd1:5'd6]}) begin
         m_ops(ins);
         cyc(1'b0, 1'b1, 1'b0);
         cyc(1'b0, 1'b0, 1'b1);
         if (alu_lat > 0) begin
            repeat (alu_lat) cyc(1'b0, 1'b0, 1'b0);
            m_zero = zval;
            m_pc   = m_pc + 8'd1;
            m_wb   = 1'b1;
         end else begin
            repeat (T - 1) cyc(1'b0, 1'b0, 1'b0);
            m_fault = 1'b1;
            m_halt  = 1'b1;
         end
      end else if (opc == 5'h1f) m_halt = 1'b1;
      else if (opc == 5'd7) m_pc = ins[7:0];
      else if (opc == 5'd8) m_pc = m_zero ? ins[7:0] : m_pc + 8'd1;
      else begin
         m_fault = m_fault | (opc > 5'd8);
         m_pc    = m_pc + 8'd1;
      end
   endtask
   task automatic run(input int n);
      for (int i = 0; i < n && !m_halt; i++) m_instr();
      if (m_halt) repeat (3) cyc(1'b0, 1'b0, 1'b0);
   endtask
   task automatic clear_rom();
      for (int i = 0; i < 256; i++) rom[i] = 16'hF800;
   endtask
   task automatic scen(input bit keep);
      chk_en = 1'b0;
      rst_n  = 1'b0;
      start  = 1'b0;
      @(posedge clk);
      #1;
      m_reset();
      chk_en  = 1'b1;
      wb_base = wb_cnt;
      cyc(1'b0, 1'b0, 1'b0);
      rst_n = 1'b1;
      start = 1'b1;
      cyc(1'b0, 1'b0, 1'b0);
      m_idle = 1'b0;
      start  = keep;
   endtask
   initial begin
      @(posedge clk);
      #1;
      clear_rom(); rom[0] = 16'h1105; rom[1] = 16'hF800;
      alu_lat = 1; zval = 1'b0; stray = 1'b0;
      scen(1'b1);
      run(4);
      chk("addi_fetch_gap", 16'(last_fetch - prev_fetch), 16'd5);
      chk("addi_pc", 16'(pc), 16'h0001);
      chk("addi_wb_count", 16'(wb_cnt - wb_base), 16'd1);
      chk("halt_start_ignored", 16'({halted, busy}), 16'b10);
      clear_rom(); rom[0] = 16'h1A60; rom[1] = 16'h4040; rom[8'h40] = 16'hF800;
      alu_lat = 2; zval = 1'b1;
      scen(1'b0);
      run(4);
      chk("bz_taken_pc", 16'(pc), 16'h0040);
      clear_rom(); rom[0] = 16'h38FF; rom[8'hFF] = 16'h0000;
      alu_lat = 1; zval = 1'b0; stray = 1'b1;
      scen(1'b0);
      run(1);
      chk("jmp_pc", 16'(pc), 16'h00FF);
      run(1);
      chk("wrap_pc", 16'(pc), 16'h0000);
      chk("wrap_fault", 16'(fault), 16'd0);
      clear_rom(); rom[0] = 16'h9000; rom[1] = 16'h4080; rom[2] = 16'h2AE0;
      rom[3] = 16'h2345; rom[4] = 16'h3407; rom[5] = 16'hF800;
      alu_lat = 1; stray = 1'b0;
      scen(1'b0);
      run(8);
      chk("illegal_fault", 16'(fault), 16'd1);
      chk("illegal_pc", 16'(pc), 16'h0005);
      clear_rom(); rom[0] = 16'h0940;
      alu_lat = 0;
      scen(1'b0);
      run(2);
      chk("timeout_state", 16'({halted, fault, busy}), 16'b110);
      chk("timeout_wb_count", 16'(wb_cnt - wb_base), 16'd0);
      clear_rom(); rom[0] = 16'h0000; rom[1] = 16'h0940;
      scen(1'b0);
      run(1);
      cyc(1'b1, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0);
      m_ops(rom[1]);
      cyc(1'b0, 1'b1, 1'b0);
      cyc(1'b0, 1'b0, 1'b1);
      cyc(1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0);
      rst_n = 1'b0;
      cyc(1'b0, 1'b0, 1'b0);
      m_reset();
      rst_n = 1'b1;
      repeat (3) cyc(1'b0, 1'b0, 1'b0);
      chk("reset_pc", 16'(pc), 16'h0000);
      chk("reset_busy", 16'(busy), 16'd0);
      chk("reset_wb_count", 16'(wb_cnt - wb_base), 16'd0);
      chk_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/cpu_seq_ctrl.md
Name: cpu_seq_ctrl

Overview:
- Multi-cycle control sequencer for the 16-bit datapath.
- Fetches instructions from a synchronous instruction ROM, decodes them, and drives register-file reads.
- Issues the enable pulse and operand select to the ALU operand mux, selects the ALU operation, then waits for the ALU's valid strobe and issues writeback.
- Owns the program counter and the zero flag.

Parameters:
- DWIDTH, 16, instruction/data word width (fixed encoding below assumes 16).
- PC_WIDTH, 8, program counter width; PC wraps modulo 2^PC_WIDTH.
- TIMEOUT, 8, maximum cycles to wait for alu_valid before fault (legal range 1..255).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, synchronous, active-low
- start  in  1  level; leaves IDLE when high
- instr_q  in  DWIDTH  ROM read data, valid the cycle after rom_en
- alu_valid  in  1  ALU result strobe (end of operand-mux/ALU enable chain)
- alu_zero  in  1  ALU result==0, sampled with alu_valid
- pc  out  PC_WIDTH  ROM address
- rom_en  out  1  ROM read pulse
- rf_rd_en  out  1  register-file read pulse
- rd_addr  out  3  destination/first-source register
- rs_addr  out  3  second-source register
- alu_mux_en  out  1  one-cycle enable to operand mux
- alu_in_sel  out  1  0 = immediate offset, 1 = rs operand
- offset  out  8  immediate field
- alu_op  out  3  0 ADD, 1 SUB, 2 AND, 3 OR
- wb_en  out  1  register-file write pulse to rd_addr
- busy  out  1  high in any state except IDLE/HALT
- halted  out  1  high in HALT
- fault  out  1  sticky; set on timeout or illegal opcode

Behaviour:
- **Encoding:** opcode=instr[15:11], rd=instr[10:8], rs=instr[7:5], imm=instr[7:0].
- **Opcodes:** 00000 NOP; 00001 ADD; 00010 ADDI; 00011 SUB; 00100 SUBI; 00101 AND; 00110 OR; 00111 JMP imm; 01000 BZ imm; 11111 HALT. Any other opcode is illegal.
- **Reset** (rst_n low at posedge):
  - state=IDLE; pc=0; zero flag=0.
  - fault, busy, halted, and all pulse outputs = 0.
  - rd_addr, rs_addr, offset, alu_op, alu_in_sel = 0.
  - Reset mid-instruction aborts it with no wb_en.
- **Pulse outputs:** rom_en, rf_rd_en, alu_mux_en and wb_en are registered and high for exactly one cycle.
- **State machine:**
  - **IDLE:** when start=1, go to FETCH.
  - **FETCH:** rom_en=1 with the current pc; go to DECODE.
  - **DECODE:** latch instr_q, then branch by opcode.
    - NOP: pc+1, go to FETCH.
    - JMP: pc<=imm[PC_WIDTH-1:0], go to FETCH.
    - BZ: pc<=imm if zero flag=1, else pc+1; go to FETCH.
    - HALT: go to HALT; pc is unchanged.
    - Illegal: set fault, pc+1, go to FETCH (executes as NOP).
    - ALU ops: drive rd_addr/rs_addr/offset/alu_op/alu_in_sel (sel=1 for ADD/SUB/AND/OR, 0 for immediate forms); rf_rd_en=1; go to ISSUE.
  - **ISSUE:** rd_q/rs_q valid this cycle; alu_mux_en=1; clear wait counter; go to WAIT.
  - **WAIT:**
    - On alu_valid: wb_en=1, zero flag<=alu_zero, pc+1, go to FETCH.
    - Otherwise increment the counter. Once TIMEOUT cycles have elapsed with no alu_valid: set fault, go to HALT, no wb_en.
  - **HALT:** terminal; exited only by reset. start is ignored.
- **Operand hold:** rd_addr, rs_addr, offset, alu_op and alu_in_sel hold from DECODE through WAIT.
- **Minimum ALU latency:** with a 1-cycle operand mux and a 1-cycle ALU, an ALU instruction takes 5 cycles, FETCH to next FETCH.
- **PC wrap:** pc+1 from 2^PC_WIDTH-1 wraps to 0. JMP/BZ truncate imm to PC_WIDTH.
- **Stray alu_valid:** alu_valid outside WAIT is ignored.
- **start deasserted while busy:** no effect; the sequencer keeps running.

Decomposition:
- **Shared package (cpu_pkg):** opcode localparams, alu_op codes, state encoding, instruction field bit positions. The decoder reuses these.
- **Sub-module:** one combinational sub-module, cpu_instr_decode. Input: instruction word. Outputs: is_alu, is_imm, is_jmp, is_bz, is_halt, is_illegal, alu_op.

Test Plan:
- Reset then start=1; ROM[0]=ADDI r1,0x05 (0x1105); alu_valid 1 cycle after alu_mux_en, with alu_zero=0 -> rom_en@pc=0; rf_rd_en with rd=1, offset=0x05, sel=0, alu_op=0; alu_mux_en next cycle; wb_en; pc=1; 5 cycles total.
- SUB r2,r3 (0x1A60) with alu_zero=1, then BZ 0x40 (0x4040) -> sel=1, rs=3, alu_op=1; after the branch pc=0x40.
- JMP 0xFF then NOP -> pc=0xFF, then pc=0x00 (wrap).
- Illegal opcode 0x9000 -> fault=1; no rf_rd_en; pc+1; execution continues.
- ALU instruction with alu_valid never asserted, TIMEOUT=8 -> after 8 WAIT cycles: halted=1, fault=1, wb_en never pulsed.
- HALT (0xF800) -> halted=1, busy=0, pc frozen, start ignored. rst_n=0 in the middle of a later ALU WAIT -> next cycle: IDLE, pc=0, no wb_en.
